// File: rtl/opsum_glb_write_arbiter.sv
// Round-robin arbiter with bounded bursts, merging per-channel opsum FIFO writes onto one GLB write port.
// Define OPSUM_ARB_STAT_EN to add the write/stall statistics counters.
module opsum_glb_write_arbiter #(
    parameter int NUM_CH    = 8,
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int BE_W     = DATA_W / 8,
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arb_clear_i,
    input  logic                     glb_stall_i,
    input  logic [NUM_CH-1:0]        opsum_write_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] opsum_write_addr_i,
    input  logic [NUM_CH*BE_W-1:0]   opsum_write_web_i,
    input  logic [NUM_CH*DATA_W-1:0] opsum_write_data_i,
    output logic [NUM_CH-1:0]        opsum_permit_pop_o,
    output logic                     glb_we_o,
    output logic [ADDR_W-1:0]        glb_addr_o,
    output logic [BE_W-1:0]          glb_web_o,
    output logic [DATA_W-1:0]        glb_wdata_o,
    output logic                     arb_busy_o,
    output logic [IDX_W-1:0]         arb_owner_o
`ifdef OPSUM_ARB_STAT_EN
    ,
    output logic [31:0]              arb_wr_cnt_o,
    output logic [31:0]              arb_stall_cnt_o
`endif
);

    // state  | meaning
    // S_IDLE | no owner; a request is granted in the same cycle
    // S_HAND | bubble after a full burst; next owner chosen, no permit
    // S_OWN  | owner_q holds the port until its burst ends or it stops requesting
    typedef enum logic [1:0] {S_IDLE, S_HAND, S_OWN} state_t;

    localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BE_W-1:0]    web_q;
    logic [DATA_W-1:0]  data_q;

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [IDX_W-1:0]    pick_off;
    logic [IDX_W:0]      pick_sum;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                grant;
    logic [NUM_CH-1:0]   permit;
    logic [ADDR_W-1:0]   addr_sel;
    logic [BE_W-1:0]     web_sel;
    logic [DATA_W-1:0]   data_sel;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
        logic [IDX_W:0] s;
        s = {1'b0, x} + 1'b1;
        return (s >= NUM_CH_W) ? '0 : s[IDX_W-1:0];
    endfunction

    // Rotate requests so the search always starts at bit 0, then map the offset back.
    assign req_dbl = {opsum_write_req_i, opsum_write_req_i} >> rr_ptr_q;
    assign req_rot = req_dbl[NUM_CH-1:0];

    always_comb begin
        pick_found = 1'b0;
        pick_off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_found = 1'b1;
                pick_off   = IDX_W'(i);
            end
        end
    end

    assign pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    assign pick_idx = (pick_sum >= NUM_CH_W) ? IDX_W'(pick_sum - NUM_CH_W) : pick_sum[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        sel_idx     = owner_q;
        grant       = 1'b0;
        permit      = '0;
        if (arb_clear_i) begin
            state_d     = S_IDLE;
            rr_ptr_d    = '0;
            burst_cnt_d = '0;
        end else if (!glb_stall_i) begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant   = 1'b1;
                        sel_idx = pick_idx;
                        owner_d = pick_idx;
                    end
                end
                S_HAND: begin
                    if (pick_found) begin
                        state_d = S_OWN;
                        owner_d = pick_idx;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_OWN: begin
                    if (opsum_write_req_i[owner_q]) begin
                        grant = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        rr_ptr_d    = next_idx(owner_q);
                        burst_cnt_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (grant) begin
                permit = NUM_CH'(1) << sel_idx;
                // Burst counter is 0 in IDLE, so BURST_LEN == 1 releases on the very first grant.
                if (burst_cnt_q == LAST_CNT) begin
                    state_d     = S_HAND;
                    rr_ptr_d    = next_idx(sel_idx);
                    burst_cnt_d = '0;
                end else begin
                    state_d     = S_OWN;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        web_sel  = '0;
        data_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_idx == IDX_W'(c)) begin
                addr_sel = opsum_write_addr_i[c*ADDR_W +: ADDR_W];
                web_sel  = opsum_write_web_i[c*BE_W +: BE_W];
                data_sel = opsum_write_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            web_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            we_q        <= grant;
            if (grant) begin
                addr_q <= addr_sel;
                web_q  <= web_sel;
                data_q <= data_sel;
            end
        end
    end

    // Reset is asynchronous, so the combinational permit is gated directly by rst_n.
    assign opsum_permit_pop_o = permit & {NUM_CH{rst_n}};
    assign glb_we_o           = we_q;
    assign glb_addr_o         = addr_q;
    assign glb_web_o          = web_q;
    assign glb_wdata_o        = data_q;
    assign arb_busy_o         = (state_q == S_OWN) | we_q;
    assign arb_owner_o        = owner_q;

`ifdef OPSUM_ARB_STAT_EN
    logic [31:0] wr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else if (arb_clear_i) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (we_q && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if ((|opsum_write_req_i) && !(|opsum_permit_pop_o) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign arb_wr_cnt_o    = wr_cnt_q;
    assign arb_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_opsum_glb_write_arbiter.sv
// Directed bench for opsum_glb_write_arbiter (NUM_CH=8, BURST_LEN=4, 32-bit address/data).
module tb_opsum_glb_write_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         stall;
    logic [7:0]   req;
    logic [255:0] addr_v;
    logic [31:0]  web_v;
    logic [255:0] data_v;
    logic [7:0]   permit;
    logic         we;
    logic [31:0]  gaddr;
    logic [3:0]   gweb;
    logic [31:0]  gdata;
    logic         busy;
    logic [2:0]   owner;
`ifdef OPSUM_ARB_STAT_EN
    logic [31:0]  wr_cnt;
    logic [31:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_addr;
    logic [3:0]  exp_web;
    logic [31:0] exp_data;
    int own_seq [4] = '{0, 3, 7, 0};

    opsum_glb_write_arbiter #(
        .NUM_CH(8), .BURST_LEN(4), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .arb_clear_i        (clr),
        .glb_stall_i        (stall),
        .opsum_write_req_i  (req),
        .opsum_write_addr_i (addr_v),
        .opsum_write_web_i  (web_v),
        .opsum_write_data_i (data_v),
        .opsum_permit_pop_o (permit),
        .glb_we_o           (we),
        .glb_addr_o         (gaddr),
        .glb_web_o          (gweb),
        .glb_wdata_o        (gdata),
        .arb_busy_o         (busy),
        .arb_owner_o        (owner)
`ifdef OPSUM_ARB_STAT_EN
        ,
        .arb_wr_cnt_o       (wr_cnt),
        .arb_stall_cnt_o    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: drive one cycle, check the permit, clock, then check the write port.
    task automatic run_vec(input string tag, input logic [7:0] rq, input logic st,
                           input logic cl, input logic [7:0] exp_perm);
        req   = rq;
        stall = st;
        clr   = cl;
        for (int c = 0; c < 8; c++) data_v[c*32 +: 32] = {8'(c), 24'(cyc)};
        #3;
        chk({tag, "_permit"}, 64'(permit), 64'(exp_perm));
        for (int c = 0; c < 8; c++) begin
            if (exp_perm[c]) begin
                exp_addr = addr_v[c*32 +: 32];
                exp_web  = web_v[c*4 +: 4];
                exp_data = data_v[c*32 +: 32];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk({tag, "_we"},   64'(we),    64'(|exp_perm));
        chk({tag, "_addr"}, 64'(gaddr), 64'(exp_addr));
        chk({tag, "_web"},  64'(gweb),  64'(exp_web));
        chk({tag, "_data"}, 64'(gdata), 64'(exp_data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        stall = 1'b0;
        req   = 8'h04;
        for (int c = 0; c < 8; c++) begin
            addr_v[c*32 +: 32] = 32'h1000 + 32'(c * 'h40);
            web_v[c*4 +: 4]    = 4'hF;
            data_v[c*32 +: 32] = '0;
        end
        exp_addr = '0;
        exp_web  = '0;
        exp_data = '0;

        // reset: outputs zero, no permit despite a pending request
        #3;
        chk("rst_permit", 64'(permit), 64'h0);
        chk("rst_we",     64'(we),     64'h0);
        chk("rst_addr",   64'(gaddr),  64'h0);
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_owner",  64'(owner),  64'h0);
        @(posedge clk);
        #1;
        req   = 8'h00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single channel 2: four grants, bubble, grant
        for (int k = 0; k < 7; k++) begin
            logic [7:0] ep [7] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04, 8'h00};
            addr_v[2*32 +: 32] = 32'h100 + 32'(2 * k);
            web_v[2*4 +: 4]    = (k % 2 == 0) ? 4'b0011 : 4'b1100;
            run_vec("t1", (k < 6) ? 8'h04 : 8'h00, 1'b0, 1'b0, ep[k]);
            if (k == 0) begin
                chk("t1_owner", 64'(owner), 64'd2);
                chk("t1_busy",  64'(busy),  64'd1);
            end
        end
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // channels 0,3,7: owner order 0,3,7,0 with four grants each
        run_vec("t2clr", 8'h89, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            int t;
            t = i / 5;
            run_vec("t2", 8'h89, 1'b0, 1'b0, (i % 5 < 4) ? 8'(1 << own_seq[t]) : 8'h00);
            if (i % 5 < 4) chk("t2_owner", 64'(owner), 64'(own_seq[t]));
        end
        run_vec("t2end", 8'h00, 1'b0, 1'b0, 8'h00);
        run_vec("t3clr", 8'h00, 1'b0, 1'b1, 8'h00);

        // channel 5 drops after two grants, channel 1 goes next
        run_vec("t3", 8'h20, 1'b0, 1'b0, 8'h20);
        run_vec("t3", 8'h20, 1'b0, 1'b0, 8'h20);
        run_vec("t3drop", 8'h02, 1'b0, 1'b0, 8'h00);
        run_vec("t3next", 8'h02, 1'b0, 1'b0, 8'h02);
        chk("t3_owner", 64'(owner), 64'd1);
        run_vec("t3end", 8'h00, 1'b0, 1'b0, 8'h00);

        // stall of three cycles mid-burst on channel 4
        run_vec("t4", 8'h10, 1'b0, 1'b0, 8'h10);
        run_vec("t4", 8'h10, 1'b0, 1'b0, 8'h10);
        for (int s = 0; s < 3; s++) begin
            run_vec("t4stall", 8'h10, 1'b1, 1'b0, 8'h00);
            chk("t4_busy",  64'(busy),  64'd1);
            chk("t4_owner", 64'(owner), 64'd4);
        end
        run_vec("t4rest", 8'h10, 1'b0, 1'b0, 8'h10);
        run_vec("t4rest", 8'h10, 1'b0, 1'b0, 8'h10);
        run_vec("t4end", 8'h00, 1'b0, 1'b0, 8'h00);

        // clear during a burst on channel 6; the pending write still completes
        run_vec("t5", 8'h40, 1'b0, 1'b0, 8'h40);
        run_vec("t5", 8'h40, 1'b0, 1'b0, 8'h40);
        req = 8'h44;
        clr = 1'b1;
        #2;
        chk("t5_we_in_clr", 64'(we), 64'd1);
        run_vec("t5clr", 8'h44, 1'b0, 1'b1, 8'h00);
        chk("t5_busy_after_clr", 64'(busy), 64'd0);
        run_vec("t5post", 8'h44, 1'b0, 1'b0, 8'h04);

        // asynchronous reset mid-burst drops the write at once
        rst_n = 1'b0;
        #1;
        chk("t6_we",     64'(we),     64'd0);
        chk("t6_permit", 64'(permit), 64'h0);
        chk("t6_busy",   64'(busy),   64'd0);
        chk("t6_addr",   64'(gaddr),  64'h0);
        req      = 8'h00;
        exp_addr = '0;
        exp_web  = '0;
        exp_data = '0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) run_vec("t6burst", 8'h04, 1'b0, 1'b0, 8'h04);
        run_vec("t6bubble", 8'h04, 1'b0, 1'b0, 8'h00);
        run_vec("t6end", 8'h00, 1'b0, 1'b0, 8'h00);

`ifdef OPSUM_ARB_STAT_EN
        // ten writes and three stalled cycles
        run_vec("t7clr", 8'h00, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) run_vec("t7a", 8'h01, 1'b0, 1'b0, 8'h01);
        run_vec("t7gap", 8'h00, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) run_vec("t7b", 8'h01, 1'b0, 1'b0, 8'h01);
        run_vec("t7gap", 8'h00, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) run_vec("t7c", 8'h01, 1'b0, 1'b0, 8'h01);
        for (int k = 0; k < 3; k++) run_vec("t7stall", 8'h01, 1'b1, 1'b0, 8'h00);
        run_vec("t7end", 8'h00, 1'b0, 1'b0, 8'h00);
        chk("t7_wr_cnt",    64'(wr_cnt),    64'd10);
        chk("t7_stall_cnt", 64'(stall_cnt), 64'd3);
        run_vec("t7clr2", 8'h00, 1'b0, 1'b1, 8'h00);
        chk("t7_wr_cnt_clr",    64'(wr_cnt),    64'd0);
        chk("t7_stall_cnt_clr", 64'(stall_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
